// File: rtl/dzcpu_useq.sv
// Microcode sequencer for the dzcpu core: fetches macro opcodes, dispatches through
// basic/CB flow LUTs, steps the micro-PC through the ucode ROM and enters interrupts.
module dzcpu_useq #(
  parameter int              UPC_W     = 8,
  parameter int              UOP_W     = 16,
  parameter int              NUM_COND  = 4,
  parameter logic [UPC_W-1:0] IRQ_FLOW = 8'hF0,
  parameter logic [7:0]      PREFIX_OP = 8'hCB
) (
  input  logic              iClock,
  input  logic              iReset,
  output logic              oMemReq,
  input  logic              iMemReady,
  input  logic [7:0]        iMemData,
  output logic [7:0]        oOpcode,
  input  logic [UPC_W-1:0]  iBasicFlowIdx,
  input  logic [UPC_W-1:0]  iExtFlowIdx,
  output logic [UPC_W-1:0]  oUpc,
  input  logic [UOP_W-1:0]  iUop,
  output logic              oUopValid,
  output logic              oPcInc,
  input  logic [NUM_COND-1:0] iCond,
  input  logic              iIrq,
  input  logic              iIrqEnable,
  output logic              oIrqAck,
  output logic [2:0]        oState,
  output logic [7:0]        oInsnCycles
);

  localparam int CSEL_W = $clog2(NUM_COND);
  localparam logic [UPC_W-1:0] UPC_ONE = {{(UPC_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DISPATCH = 3'd2,
    S_RUN      = 3'd3,
    S_STALL    = 3'd4,
    S_END      = 3'd5,
    S_IRQ      = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [UPC_W-1:0]  upc_q, upc_d;
  logic [7:0]        opcode_q, opcode_d;
  logic              ext_q, ext_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        insn_cycles_q, insn_cycles_d;

  logic              uop_ipc_s;
  logic [2:0]        uop_seq_s;
  logic [CSEL_W-1:0] uop_csel_s;
  logic [UPC_W-1:0]  uop_target_s;
  logic              cond_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign uop_ipc_s    = iUop[UOP_W-1];
  assign uop_seq_s    = iUop[UOP_W-2:UOP_W-4];
  assign uop_csel_s   = iUop[UOP_W-5 -: CSEL_W];
  assign uop_target_s = iUop[UPC_W-1:0];
  assign cond_s       = iCond[uop_csel_s];

  // State register
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q       <= S_IDLE;
      upc_q         <= '0;
      opcode_q      <= 8'h00;
      ext_q         <= 1'b0;
      cnt_q         <= 8'h00;
      insn_cycles_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      upc_q         <= upc_d;
      opcode_q      <= opcode_d;
      ext_q         <= ext_d;
      cnt_q         <= cnt_d;
      insn_cycles_q <= insn_cycles_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    upc_d         = upc_q;
    opcode_d      = opcode_q;
    ext_d         = ext_q;
    insn_cycles_d = insn_cycles_q;
    // The counter runs in every active state; END overrides it with a clear.
    if (state_q == S_IDLE) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = sat_inc(cnt_q);
    end
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (iMemReady) begin
          opcode_d = iMemData;
          state_d  = S_DISPATCH;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_DISPATCH: begin
        upc_d   = ext_q ? iExtFlowIdx : iBasicFlowIdx;
        ext_d   = 1'b0;
        state_d = S_RUN;
      end
      S_RUN: begin
        case (uop_seq_s)
          3'd1: begin
            if (iMemReady) begin
              upc_d = upc_q + UPC_ONE;
            end else begin
              state_d = S_STALL;
            end
          end
          3'd2: state_d = S_END;
          3'd3: begin
            if (cond_s) begin
              state_d = S_END;
            end else begin
              upc_d = upc_q + UPC_ONE;
            end
          end
          3'd4: begin
            if (!cond_s) begin
              state_d = S_END;
            end else begin
              upc_d = upc_q + UPC_ONE;
            end
          end
          3'd5: begin
            ext_d   = 1'b1;
            state_d = S_FETCH;
          end
          3'd6: begin
            if (cond_s) begin
              upc_d = uop_target_s;
            end else begin
              upc_d = upc_q + UPC_ONE;
            end
          end
          default: upc_d = upc_q + UPC_ONE;
        endcase
      end
      S_STALL: begin
        if (iMemReady) begin
          state_d = S_RUN;
        end else begin
          state_d = S_STALL;
        end
      end
      S_END: begin
        insn_cycles_d = sat_inc(cnt_q);
        cnt_d         = 8'h00;
        if (iIrq && iIrqEnable) begin
          state_d = S_IRQ;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_IRQ: begin
        upc_d   = IRQ_FLOW;
        state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded strobes
  always_comb begin
    oMemReq   = 1'b0;
    oUopValid = 1'b0;
    oPcInc    = 1'b0;
    oIrqAck   = 1'b0;
    case (state_q)
      S_FETCH: oMemReq = 1'b1;
      S_RUN: begin
        oUopValid = 1'b1;
        oPcInc    = uop_ipc_s;
      end
      S_IRQ:   oIrqAck = 1'b1;
      default: oMemReq = 1'b0;
    endcase
  end

  assign oUpc        = upc_q;
  assign oOpcode     = opcode_q;
  assign oState      = state_q;
  assign oInsnCycles = insn_cycles_q;

endmodule

// File: doc/dzcpu_useq.md
Name: dzcpu_useq

Overview:
- Parametrised microcode sequencer for the next-generation dzcpu core.
- Fetches macro opcodes over a ready/valid memory handshake with wait states, and dispatches to basic or CB-prefixed micro-flows through external LUTs.
- Steps the micro-PC through an external ucode ROM, with conditional end/branch on a generic condition vector and interrupt entry at instruction boundaries.
- Qualifies datapath writes via oUopValid; the datapath itself stays outside this block.

Parameters:
- UPC_W, 8, micro-PC / flow-index width.
- UOP_W, 16, micro-op word width; must be >= UPC_W + 4 + CSEL_W.
- NUM_COND, 4, condition inputs (power of 2, >= 2); CSEL_W = clog2(NUM_COND).
- IRQ_FLOW, 8'hF0, micro-PC entry of the interrupt flow.
- PREFIX_OP, 8'hCB, opcode value reported as prefix (informational; dispatch is driven by the SEQ code).

Ports:
- iClock  in  1  clock.
- iReset  in  1  synchronous, active-high reset.
- oMemReq  out  1  opcode fetch request; held until iMemReady.
- iMemReady  in  1  fetch data valid this cycle.
- iMemData  in  8  fetched opcode.
- oOpcode  out  8  latched opcode; drives both flow LUTs.
- iBasicFlowIdx  in  UPC_W  basic LUT output for oOpcode.
- iExtFlowIdx  in  UPC_W  CB LUT output for oOpcode.
- oUpc  out  UPC_W  ROM address.
- iUop  in  UOP_W  ROM data (combinational on oUpc).
- oUopValid  out  1  iUop executes this cycle.
- oPcInc  out  1  macro PC increment strobe.
- iCond  in  NUM_COND  condition flags from datapath.
- iIrq  in  1  level interrupt request.
- iIrqEnable  in  1  IME.
- oIrqAck  out  1  one-cycle acknowledge.
- oState  out  3  current state encoding.
- oInsnCycles  out  8  cycles consumed by the last completed instruction.

Behaviour:
- Reset values: state IDLE; oUpc=0; oOpcode=0; rExt=0; cycle counter=0; oInsnCycles=0; all strobes 0.
- Reset mid-operation aborts everything. The next cycle is IDLE regardless of an outstanding fetch, and a late iMemReady is ignored.
- Micro-op fields:
  - IPC = iUop[UOP_W-1].
  - SEQ = iUop[UOP_W-2:UOP_W-4].
  - CSEL = iUop[UOP_W-5 -: CSEL_W].
  - TARGET = iUop[UPC_W-1:0].
  - c = iCond[CSEL].
- SEQ codes:
  - 0 continue.
  - 1 wait-mem: stall on this uop until iMemReady.
  - 2 end.
  - 3 end if c.
  - 4 end if !c.
  - 5 prefix dispatch.
  - 6 branch to TARGET if c, else continue.
  - 7 treated as continue.
- States and encodings: IDLE=0, FETCH=1, DISPATCH=2, RUN=3, STALL=4, END=5, IRQ=6.
- IDLE -> FETCH unconditionally.
- FETCH:
  - oMemReq=1.
  - On iMemReady, latch iMemData into oOpcode and go to DISPATCH.
  - Unbounded wait.
- DISPATCH:
  - oUpc <= rExt ? iExtFlowIdx : iBasicFlowIdx.
  - Clear rExt and go to RUN.
  - Opcode-ready to first uop = 2 cycles.
- RUN (oUopValid=1):
  - oPcInc = IPC in every valid cycle.
  - SEQ 0/7/failed cond: oUpc+1, wrapping modulo 2^UPC_W.
  - SEQ 6 taken: oUpc <= TARGET.
  - SEQ 1 with !iMemReady: go to STALL; oUpc held; oUopValid=0 in STALL; oPcInc suppressed.
  - SEQ 1 with iMemReady: acts as continue.
  - End condition met: go to END.
  - SEQ 5: set rExt and go to FETCH; the uop executes once (oUopValid=1 that cycle).
- STALL: stays until iMemReady, then returns to RUN on the same oUpc. That uop re-executes with oUopValid=1 and takes the SEQ 1 ready path.
- END:
  - oInsnCycles <= counter+1, where the counter counts every cycle from FETCH entry through END inclusive, saturating at 255. Counter then clears.
  - If iIrq & iIrqEnable: go to IRQ.
  - Else: go to FETCH.
- IRQ:
  - oIrqAck=1 for exactly one cycle; oUpc <= IRQ_FLOW; go to RUN.
  - IRQ flows end normally.
  - Interrupts are sampled only in END, never mid-flow or mid-prefix.
- Simultaneous iIrq with prefix dispatch: the prefix completes first; the interrupt is sampled at the END of the extended flow.
- oOpcode holds its value throughout RUN/STALL/END; the datapath decodes register fields from it.

Test Plan:
- Reset, then opcode 0x00 ready on the first FETCH cycle, basic LUT=0x10, ROM[0x10] SEQ=2 IPC=1 -> oUpc=0x10 two cycles after ready; one oPcInc; back to FETCH; oInsnCycles=4.
- Fetch with iMemReady delayed 3 cycles -> oMemReq held high 4 cycles; oOpcode updates only on ready; oInsnCycles=7.
- Opcode 0xCB, ROM SEQ=5, second byte 0x7C, ext LUT=0x80 -> DISPATCH loads 0x80 (not the basic index); rExt cleared afterwards.
- ROM SEQ=6 CSEL=1 TARGET=0x20 with iCond=4'b0010 -> oUpc=0x20; with iCond=0 -> oUpc increments; SEQ=3 with c=0 continues, with c=1 ends.
- SEQ=1 with iMemReady low 2 cycles -> state 4 for 2 cycles; oUopValid and oPcInc low; same oUpc re-executes; oUpc=0xFF continue wraps to 0x00.
- iIrq=1, iIrqEnable=1 asserted mid-flow -> no effect until END; then one oIrqAck pulse and oUpc=0xF0. iIrqEnable=0 -> FETCH. iReset during STALL -> IDLE next cycle, all outputs at reset values.
